// File: rtl/mvu_pe_acc_pkg.sv
// ----------------------------------------------------------------------------
// mvau_defn -- shared definitions for the MVU processing-element accumulator.
//
// Purpose : default word lengths, the fold-counter width helper and the
//           shared accumulator / partial-sum word typedefs used by the
//           mvu_pe_acc interface and module.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package mvau_defn;

  // Default adder-tree sum width, accumulator width and synapse fold.
  localparam int unsigned TI_DEF = 32'd16;
  localparam int unsigned TO_DEF = 32'd24;
  localparam int unsigned SF_DEF = 32'd4;

  // Word types at the default widths.
  typedef logic [TI_DEF-1:0] sum_word_t;
  typedef logic [TO_DEF-1:0] acc_word_t;

  // Fold-counter width: $clog2(SF), never below one bit so SF == 1 still
  // yields a legal (constant-zero) counter.
  function automatic int unsigned fold_cnt_w(input int unsigned sf);
    if (sf > 32'd1) begin
      return $clog2(sf);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage : mvau_defn

// File: rtl/mvu_pe_acc_if.sv
// ----------------------------------------------------------------------------
// mvu_pe_acc_if -- valid/ready streams around the PE accumulator.
//
// Purpose : bundles the partial-sum input stream and the dot-product output
//           stream of mvu_pe_acc.
// Signals : in_v/in_acc/in_rdy    partial-sum stream into the accumulator
//           out_v/out_acc/out_rdy completed dot-product stream out of it
// Modports: slave  -- the accumulator (consumes in_*, produces out_*)
//           master -- the environment (produces in_*, consumes out_*)
// ----------------------------------------------------------------------------
interface mvu_pe_acc_if
  import mvau_defn::*;
#(
  parameter int unsigned TI = TI_DEF,
  parameter int unsigned TO = TO_DEF
) ();

  logic          in_v;
  logic [TI-1:0] in_acc;
  logic          in_rdy;
  logic          out_v;
  logic [TO-1:0] out_acc;
  logic          out_rdy;

  modport slave (
    input  in_v, in_acc, out_rdy,
    output in_rdy, out_v, out_acc
  );

  modport master (
    output in_v, in_acc, out_rdy,
    input  in_rdy, out_v, out_acc
  );

endinterface : mvu_pe_acc_if

// File: rtl/mvu_pe_acc.sv
// ----------------------------------------------------------------------------
// mvu_pe_acc -- PE accumulator for a matrix-vector unit.
//
// Purpose : accumulates SF signed partial sums (TI bits, sign-extended to TO)
//           into one TO-bit dot product, wrapping modulo 2^TO, and presents
//           the result on a registered valid/ready output.
// Ports   : aclk    -- clock, all state on the rising edge
//           aresetn -- asynchronous active-low reset
//           s       -- mvu_pe_acc_if.slave (in_v/in_acc/in_rdy,
//                      out_v/out_acc/out_rdy)
// ----------------------------------------------------------------------------
module mvu_pe_acc
  import mvau_defn::*;
#(
  parameter int unsigned TI = TI_DEF,
  parameter int unsigned TO = TO_DEF,
  parameter int unsigned SF = SF_DEF
) (
  input logic          aclk,
  input logic          aresetn,
  mvu_pe_acc_if.slave  s
);

  localparam int unsigned   CW      = fold_cnt_w(SF);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_LAST = CW'(SF - 32'd1);

  logic [CW-1:0] r_cnt;
  logic [TO-1:0] r_acc;
  logic          r_out_v;
  logic [TO-1:0] r_out_acc;

  logic [TO-1:0] w_ext;
  logic [TO-1:0] w_sum;
  logic          w_final;
  logic          w_in_rdy;
  logic          w_accept;

  // Sign-extend the incoming partial sum and form this beat's running total;
  // the first beat of a fold replaces the accumulator rather than adding.
  always_comb begin
    w_ext = TO'($signed(s.in_acc));
    w_sum = w_ext;
    if (r_cnt == CNT_ZERO) begin
      w_sum = w_ext;
    end else begin
      w_sum = r_acc + w_ext;
    end
  end

  // Only the final beat of a fold can be held off, and only while an
  // earlier result is still waiting for the downstream to take it.
  assign w_final  = (r_cnt == CNT_LAST);
  assign w_in_rdy = !w_final || !r_out_v || s.out_rdy;
  assign w_accept = s.in_v && w_in_rdy;

  assign s.in_rdy  = w_in_rdy;
  assign s.out_v   = r_out_v;
  assign s.out_acc = r_out_acc;

  // Fold counter: one step per accepted beat, wrapping after the final beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= CNT_ZERO;
    end else if (w_accept) begin
      if (w_final) begin
        r_cnt <= CNT_ZERO;
      end else begin
        r_cnt <= r_cnt + CW'(1'b1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Running accumulator. The final beat goes straight to the output
  // register, so it is never written here (and never at all when SF == 1).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_acc <= {TO{1'b0}};
    end else if (w_accept && !w_final) begin
      r_acc <= w_sum;
    end else begin
      r_acc <= r_acc;
    end
  end

  // Output register: loads on a final accept (even while handing off the
  // previous result, giving back-to-back results), clears on a bare handoff
  // and otherwise holds.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_v   <= 1'b0;
      r_out_acc <= {TO{1'b0}};
    end else if (w_accept && w_final) begin
      r_out_v   <= 1'b1;
      r_out_acc <= w_sum;
    end else if (r_out_v && s.out_rdy) begin
      r_out_v   <= 1'b0;
      r_out_acc <= r_out_acc;
    end else begin
      r_out_v   <= r_out_v;
      r_out_acc <= r_out_acc;
    end
  end

endmodule : mvu_pe_acc

// File: tb/tb_mvu_pe_acc.sv
// ----------------------------------------------------------------------------
// tb_mvu_pe_acc -- self-checking bench for mvu_pe_acc.
//
// Three instances share one input stream and one out_rdy:
//   dut 0 : TI=8 TO=16 SF=4
//   dut 1 : TI=8 TO=8  SF=2
//   dut 2 : TI=8 TO=16 SF=1
// A behavioural model per instance (beats accepted so far in the fold,
// running integer sum, pending result) predicts in_rdy, out_v and out_acc
// every cycle; directed scenarios add explicit constant checks.
// ----------------------------------------------------------------------------
module tb_mvu_pe_acc;

  logic       aclk    = 1'b0;
  logic       aresetn = 1'b0;
  logic       tb_v    = 1'b0;
  logic [7:0] tb_d    = 8'h00;
  logic       tb_ordy = 1'b0;

  always #5 aclk = ~aclk;

  mvu_pe_acc_if #(.TI(8), .TO(16)) if0 ();
  mvu_pe_acc_if #(.TI(8), .TO(8))  if1 ();
  mvu_pe_acc_if #(.TI(8), .TO(16)) if2 ();

  mvu_pe_acc #(.TI(8), .TO(16), .SF(4)) u_dut0 (.aclk(aclk), .aresetn(aresetn), .s(if0));
  mvu_pe_acc #(.TI(8), .TO(8),  .SF(2)) u_dut1 (.aclk(aclk), .aresetn(aresetn), .s(if1));
  mvu_pe_acc #(.TI(8), .TO(16), .SF(1)) u_dut2 (.aclk(aclk), .aresetn(aresetn), .s(if2));

  assign if0.in_v = tb_v;  assign if0.in_acc = tb_d;  assign if0.out_rdy = tb_ordy;
  assign if1.in_v = tb_v;  assign if1.in_acc = tb_d;  assign if1.out_rdy = tb_ordy;
  assign if2.in_v = tb_v;  assign if2.in_acc = tb_d;  assign if2.out_rdy = tb_ordy;

  logic        rdy_o [3];
  logic        v_o   [3];
  logic [15:0] acc_o [3];

  assign rdy_o[0] = if0.in_rdy;  assign v_o[0] = if0.out_v;  assign acc_o[0] = if0.out_acc;
  assign rdy_o[1] = if1.in_rdy;  assign v_o[1] = if1.out_v;  assign acc_o[1] = {8'h00, if1.out_acc};
  assign rdy_o[2] = if2.in_rdy;  assign v_o[2] = if2.out_v;  assign acc_o[2] = if2.out_acc;

  // Reference model state
  int sf_m   [3] = '{4, 2, 1};
  int mask_m [3] = '{32'hFFFF, 32'hFF, 32'hFFFF};
  int nbeat_m[3];   // beats already accepted in the current fold
  int sum_m  [3];   // integer sum of the current fold
  bit ev_m   [3];   // a result is pending on the output
  int eacc_m [3];   // value of that result
  bit obs_rdy[3];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      nbeat_m[k] = 0; sum_m[k] = 0; ev_m[k] = 1'b0; eacc_m[k] = 0;
    end
  endtask

  // One clock cycle: drive, check in_rdy, clock, check outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit ordy);
    bit acc_b [3];
    bit exp_rdy;
    bit fin;
    tb_v = v; tb_d = d; tb_ordy = ordy;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_rdy    = (nbeat_m[k] != sf_m[k] - 1) || !ev_m[k] || ordy;
      obs_rdy[k] = rdy_o[k];
      checks++;
      if (rdy_o[k] !== exp_rdy) begin
        errors++;
        $display("FAIL in_rdy dut%0d t=%0t: got %b expected %b", k, $time, rdy_o[k], exp_rdy);
      end
      acc_b[k] = v && exp_rdy;
    end
    @(posedge aclk);
    #1;
    for (int k = 0; k < 3; k++) begin
      fin = acc_b[k] && (nbeat_m[k] == sf_m[k] - 1);
      if (acc_b[k]) begin
        if (nbeat_m[k] == 0) sum_m[k] = int'($signed(d));
        else                 sum_m[k] = sum_m[k] + int'($signed(d));
        nbeat_m[k] = fin ? 0 : nbeat_m[k] + 1;
      end
      if (fin) begin
        ev_m[k]   = 1'b1;
        eacc_m[k] = sum_m[k] & mask_m[k];
      end else if (ev_m[k] && ordy) begin
        ev_m[k] = 1'b0;
      end
      checks++;
      if (v_o[k] !== ev_m[k]) begin
        errors++;
        $display("FAIL out_v dut%0d t=%0t: got %b expected %b", k, $time, v_o[k], ev_m[k]);
      end
      checks++;
      if (acc_o[k] !== eacc_m[k][15:0]) begin
        errors++;
        $display("FAIL out_acc dut%0d t=%0t: got %h expected %h", k, $time, acc_o[k], eacc_m[k][15:0]);
      end
    end
  endtask

  // Offer a beat until the SF=4 instance is predicted to take it.
  task automatic send0(input logic [7:0] d, input bit ordy);
    bit taken;
    taken = 1'b0;
    for (int n = 0; n < 20 && !taken; n++) begin
      taken = (nbeat_m[0] != 3) || !ev_m[0] || ordy;
      step(1'b1, d, ordy);
    end
    checks++;
    if (!taken) begin
      errors++;
      $display("FAIL send0_timeout: beat %h never accepted", d);
    end
  endtask

  task automatic test_reset();
    tb_v = 1'b0;
    aresetn = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (v_o[k] !== 1'b0 || acc_o[k] !== 16'h0000 || rdy_o[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d: got v=%b acc=%h rdy=%b expected v=0 acc=0000 rdy=1",
                 k, v_o[k], acc_o[k], rdy_o[k]);
      end
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_base_fold();
    test_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1);
    checks++;
    if (v_o[0] !== 1'b1 || acc_o[0] !== 16'h000A) begin
      errors++;
      $display("FAIL base_fold: got v=%b acc=%h expected v=1 acc=000a", v_o[0], acc_o[0]);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (v_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL base_fold_clear: got v=%b expected 0", v_o[0]);
    end
  endtask

  task automatic test_signed();
    test_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'b1);
    checks++;
    if (acc_o[0] !== 16'hFFFC) begin
      errors++;
      $display("FAIL signed: got %h expected fffc", acc_o[0]);
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    for (int i = 1; i <= 4; i++) send0(8'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      send0(8'd5, 1'b0);
      checks++;
      if (v_o[0] !== 1'b1 || acc_o[0] !== 16'd10) begin
        errors++;
        $display("FAIL bp_hold: got v=%b acc=%h expected v=1 acc=000a", v_o[0], acc_o[0]);
      end
    end
    step(1'b1, 8'd5, 1'b0);
    checks++;
    if (obs_rdy[0] !== 1'b0 || acc_o[0] !== 16'd10) begin
      errors++;
      $display("FAIL bp_stall: got rdy=%b acc=%h expected rdy=0 acc=000a", obs_rdy[0], acc_o[0]);
    end
    step(1'b1, 8'd5, 1'b1);
    checks++;
    if (obs_rdy[0] !== 1'b1 || v_o[0] !== 1'b1 || acc_o[0] !== 16'd20) begin
      errors++;
      $display("FAIL bp_back_to_back: got rdy=%b v=%b acc=%h expected rdy=1 v=1 acc=0014",
               obs_rdy[0], v_o[0], acc_o[0]);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    step(1'b1, 8'd100, 1'b1);
    step(1'b1, 8'd100, 1'b1);
    checks++;
    if (v_o[1] !== 1'b1 || acc_o[1] !== 16'h00C8) begin
      errors++;
      $display("FAIL wrap: got v=%b acc=%h expected v=1 acc=00c8", v_o[1], acc_o[1]);
    end
  endtask

  task automatic test_reset_midfold();
    test_reset();
    step(1'b1, 8'd7, 1'b1);
    step(1'b1, 8'd7, 1'b1);
    test_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'd5, 1'b1);
    checks++;
    if (v_o[0] !== 1'b1 || acc_o[0] !== 16'd20) begin
      errors++;
      $display("FAIL reset_midfold: got v=%b acc=%h expected v=1 acc=0014", v_o[0], acc_o[0]);
    end
  endtask

  task automatic test_sf1();
    test_reset();
    step(1'b1, 8'd7, 1'b1);
    checks++;
    if (v_o[2] !== 1'b1 || acc_o[2] !== 16'd7) begin
      errors++;
      $display("FAIL sf1_first: got v=%b acc=%h expected v=1 acc=0007", v_o[2], acc_o[2]);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (v_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL sf1_gap: got v=%b expected 0", v_o[2]);
    end
    step(1'b1, 8'd3, 1'b1);
    checks++;
    if (v_o[2] !== 1'b1 || acc_o[2] !== 16'd3) begin
      errors++;
      $display("FAIL sf1_second: got v=%b acc=%h expected v=1 acc=0003", v_o[2], acc_o[2]);
    end
    step(1'b1, 8'hFE, 1'b1);
    checks++;
    if (v_o[2] !== 1'b1 || acc_o[2] !== 16'hFFFE) begin
      errors++;
      $display("FAIL sf1_neg: got v=%b acc=%h expected v=1 acc=fffe", v_o[2], acc_o[2]);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_base_fold();
    test_signed();
    test_backpressure();
    test_wrap();
    test_reset_midfold();
    test_sf1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mvu_pe_acc

// File: doc/mvu_pe_acc.md
MVU_PE_ACC -- requirements
Module: mvu_pe_acc

Interface
REQ-001 Parameter TI, default 16: width of the adder-tree sum word consumed per beat, signed two's complement.
REQ-002 Parameter TO, default 24: accumulator and output width; TO >= TI.
REQ-003 Parameter SF, default 4: synapse fold, i.e. beats accumulated per output; SF >= 1.
REQ-004 aclk  input  1  single clock; all state updates on its rising edge.
REQ-005 aresetn  input  1  reset; asynchronous, active-low.
REQ-006 in_v  input  1  in_acc holds a valid partial sum.
REQ-007 in_acc  input  TI  partial sum from the PE adder tree.
REQ-008 in_rdy  output  1  block accepts in_acc this cycle.
REQ-009 out_v  output  1  out_acc holds a completed dot product.
REQ-010 out_acc  output  TO  accumulated result.
REQ-011 out_rdy  input  1  downstream takes out_acc this cycle.

Function
REQ-012 A beat is accepted when in_v && in_rdy are both high at a rising edge.
REQ-013 in_acc is sign-extended to TO bits before any arithmetic.
REQ-014 A fold counter runs 0..SF-1 and advances by one per accepted beat.
REQ-015 The counter wraps from SF-1 to 0.
REQ-016 Accept at count 0: acc <= ext(in_acc), replacing the accumulator, not adding to it.
REQ-017 Accept at count > 0: acc <= acc + ext(in_acc), modulo 2^TO.
- No saturation.
- No overflow flag.
REQ-018 Accept at count SF-1 is the final beat.
- out_acc <= final sum (acc + ext(in_acc), or ext(in_acc) when SF == 1).
- out_v <= 1.
- Latency: exactly one cycle from the final accept to out_v high.
REQ-019 in_rdy = (count != SF-1) || !out_v || out_rdy, combinationally.
- Non-final beats are never stalled by the output.
- The final beat stalls only while a result is pending and out_rdy is low.
REQ-020 out_v and out_acc shall hold stable while out_v && !out_rdy.
REQ-021 Output handoff and next final beat in the same cycle:
- Condition: out_v && out_rdy && final accept in the same cycle.
- out_v stays 1.
- out_acc takes the new sum, so back-to-back results are possible every cycle when SF == 1.
REQ-022 Output handoff with no final accept: out_v && out_rdy without a final accept clears out_v next cycle.
REQ-023 When in_v is low, the accumulator and counter hold; gaps in the input stream are legal at any count.
REQ-024 When SF == 1:
- Every accepted beat is final.
- The counter is constant 0.
- The accumulator register is unused.

Reset
REQ-025 While aresetn is low: acc = 0, count = 0, out_v = 0, out_acc = 0, asynchronously.
REQ-026 Reset mid-fold discards the partial sum; the first beat after release is treated as count 0.
REQ-027 in_rdy is high whenever out_v is 0, including during and directly after reset.

Structure
REQ-028 The fold-counter width $clog2(SF) (minimum 1) and any shared accumulator/word-length typedefs belong in the shared mvau_defn package.
REQ-029 Implement as a single module with counter, accumulator and output register inline; no sub-module is required.

Verification
REQ-030 Base fold: TI=8, TO=16, SF=4, out_rdy=1, beats 1,2,3,4.
- out_v high one cycle after beat 4.
- out_acc = 0x000A.
- out_v low the following cycle.
REQ-031 Signed: same configuration, beats 0xFF x4 -> out_acc = 0xFFFC (-4).
REQ-032 Backpressure: out_rdy=0; fold 1,2,3,4, then fold 5,5,5,5.
- Result 10 is held.
- Beats 5,5,5 are accepted.
- in_rdy is low on the 4th beat.
- Raise out_rdy: 10 is taken the same cycle the final beat is accepted.
- out_acc = 20 next cycle, out_v continuously high.
REQ-033 Wrap: TI=8, TO=8, SF=2, beats 100,100 -> out_acc = 0xC8.
REQ-034 Reset mid-fold: SF=4; accept 7,7, pulse aresetn low, then beats 5,5,5,5.
- out_v = 0 during reset.
- Result = 20; no carry-over of 14.
REQ-035 SF=1: beats 7, gap, 3, -2 with out_rdy=1.
- out_acc = 7, 3, 0x..FE, each one cycle after its accept.
- out_v low during the gap cycle.
